io_bus_ctrl: RTL and testbench
==============================

# io_bus_ctrl

Parametrised memory-mapped I/O controller placed between the processor's data port and the synchronous data memory (`memo`) in the CPU top level. It decodes a block of word addresses at the top of the address space into NPORTS output registers, NPORTS synchronised input registers and an interrupt mask/pending pair. All other addresses pass through to memory. Unlike the single-address scheme it supersedes, it provides multiple ports, input change detection and a maskable, level-sensitive interrupt request to the processor.

## Interface
- `NBITS`, 8: data width of the bus and of each port.
- `NPORTS`, 4: number of input/output port pairs (1..8).
- `ABITS`, NBITS-2: word-address width.
- `IO_BASE`, 2**ABITS-(2*NPORTS+2): first I/O word address. The default places the block at the top of the address space, for example 'h36 with the default parameters.

Ports:
- `clock`  in  1: single clock.
- `reset`  in  1: synchronous, active-high reset.
- `mem_address`  in  ABITS: word address from the processor.
- `mem_write_data`  in  NBITS: store data from the processor.
- `mem_write`  in  1: store strobe from the processor.
- `mem_read_data`  out  NBITS: load data returned to the processor.
- `ram_q`  in  NBITS: `memo` read data, valid one cycle after the address.
- `ram_wren`  out  1: write enable to `memo`.
- `entrada`  in  NPORTS*NBITS: asynchronous external inputs. Port k occupies bits [k*NBITS +: NBITS].
- `saida`  out  NPORTS*NBITS: registered external outputs, with the same packing as `entrada`.
- `interrupt`  out  1: level interrupt request to the processor.

## Operation
- Decode: `io = (mem_address >= IO_BASE) && (mem_address - IO_BASE < 2*NPORTS+2)`. The offset is `o = mem_address - IO_BASE`, computed in ABITS-bit arithmetic.
- Register map by offset:
  - OUT[k] at o=k: read/write.
  - IN[k] at o=NPORTS+k: read-only; writes are ignored.
  - IRQ_MASK at o=2*NPORTS: read/write. Bits [NPORTS-1:0] are used; upper bits read as 0.
  - IRQ_PEND at o=2*NPORTS+1: write-1-to-clear. Upper bits read as 0.
- `ram_wren = mem_write & ~io`. This is combinational, and I/O stores never reach memory.
- Input path: each port has a two-flop synchroniser, s1 followed by s2. IN[k] reads s2. When s2 differs from its previous-cycle value (s3), pending bit k is set.
- Pending update per bit: `pend <= (pend & ~clr) | set`. If set and clear occur in the same cycle, set wins.
- `interrupt` is registered: `interrupt <= |(pend & mask)`. The value reflects state from the previous cycle.
- Read path: both memory and I/O reads have a latency of one cycle.
  - Each cycle the block registers `io_q` (the selected I/O register value, sampled before any same-cycle write) and `sel_q <= io`.
  - `mem_read_data = sel_q ? io_q : ram_q`, combinational.
- A load from an unmapped offset cannot occur, because `io` covers only the mapped range.

## Timing
- Reset (synchronous, on the clock edge while `reset`=1):
  - `saida`, mask, pend, s1/s2/s3, `io_q`, `sel_q` and `interrupt` are all cleared to 0.
  - After reset, `mem_read_data` equals `ram_q`.
  - Changes in s2 caused by reset do not set pend.
- Output write: a store in cycle t updates `saida` at the t+1 edge. A same-address load in cycle t returns the old value at t+1.
- Input to pending: from an `entrada` change to pend set takes 3 edges, and `interrupt` rises 1 edge later (4 edges total, with mask bit set).
- Clear to deassert: a write-1 to pend in cycle t clears pend at t+1, and `interrupt` drops at t+2, unless a new set occurred.
- Asserting `reset` mid-operation discards pending bits and returns all outputs to zero on the next edge.

## Structure
- Package `io_bus_pkg`:
  - Offset constants as functions of NPORTS: `OFF_OUT`, `OFF_IN`, `OFF_MASK`, `OFF_PEND`.
  - Enum `io_reg_e` {REG_OUT, REG_IN, REG_MASK, REG_PEND, REG_NONE} for the decode result.
- Sub-module `io_port_sync`: one instance per port. Contains the s1/s2/s3 flops and produces `din` and the `changed` pulse.
- The top-level block holds the decoder, the register file, the pend/mask logic and the read mux.

## Test plan
- Reset: hold `reset` for 2 cycles with `entrada`='hFF..., then release. Required: `saida`=0, `interrupt`=0, and no pend bits set through 5 idle cycles.
- Output write: store 'hA5 to IO_BASE+1. Required: `saida`[15:8]='hA5 on the next edge, `ram_wren`=0, and a load from the same address returns 'hA5.
- Pass-through: store 'h3C to address 5, then load address 5. Required: `ram_wren`=1 during the store, and `mem_read_data`=`ram_q`=’h3C one cycle after the load address.
- Interrupt: write mask='h04, then change `entrada` port 2 from 0 to 'h11. Required: IN[2] reads 'h11, pend='h04, and `interrupt`=1 at the 4th edge. Writing pend='h04 clears pend, and `interrupt`=0 two edges later.
- Masked and simultaneous: with mask=0, a change on port 0 sets pend bit 0 and `interrupt` stays 0. A clear of bit 0 in the same cycle as a new change leaves bit 0 set.
- Write to IN: store 'hFF to IO_BASE+NPORTS. Required: IN[0] is unchanged and `ram_wren`=0.

Source files
------------

// File: rtl/io_bus_pkg.sv
// io_bus_pkg: shared constants and types for the memory-mapped I/O controller.
//   OFF_OUT/OFF_IN/OFF_MASK/OFF_PEND : register-map offsets relative to IO_BASE
//   IO_SPAN                          : number of mapped word addresses
//   io_reg_e                         : address-decode result
package io_bus_pkg;

   typedef enum logic [2:0] {
      REG_OUT,
      REG_IN,
      REG_MASK,
      REG_PEND,
      REG_NONE
   } io_reg_e;

   // Output ports start the block; written as a function so the map reads uniformly.
   function automatic int unsigned OFF_OUT(input int unsigned nports);
      return 0 * nports;
   endfunction

   function automatic int unsigned OFF_IN(input int unsigned nports);
      return nports;
   endfunction

   function automatic int unsigned OFF_MASK(input int unsigned nports);
      return 2 * nports;
   endfunction

   function automatic int unsigned OFF_PEND(input int unsigned nports);
      return 2 * nports + 1;
   endfunction

   function automatic int unsigned IO_SPAN(input int unsigned nports);
      return 2 * nports + 2;
   endfunction

endpackage

// File: rtl/io_bus_ctrl_if.sv
// io_bus_ctrl_if: processor data port, memory port and external I/O pins of io_bus_ctrl.
//   master : processor/memory/pin side (drives address, store data, ram_q, entrada)
//   slave  : the controller (drives mem_read_data, ram_wren, saida, interrupt)
interface io_bus_ctrl_if #(
   parameter int unsigned NBITS  = 8,
   parameter int unsigned NPORTS = 4,
   parameter int unsigned ABITS  = NBITS - 2
) ();

   logic [ABITS-1:0]        mem_address;
   logic [NBITS-1:0]        mem_write_data;
   logic                    mem_write;
   logic [NBITS-1:0]        mem_read_data;
   logic [NBITS-1:0]        ram_q;
   logic                    ram_wren;
   logic [NPORTS*NBITS-1:0] entrada;
   logic [NPORTS*NBITS-1:0] saida;
   logic                    interrupt;

   modport master (
      output mem_address, mem_write_data, mem_write, ram_q, entrada,
      input  mem_read_data, ram_wren, saida, interrupt
   );

   modport slave (
      input  mem_address, mem_write_data, mem_write, ram_q, entrada,
      output mem_read_data, ram_wren, saida, interrupt
   );

endinterface

// File: rtl/io_port_sync.sv
// io_port_sync: two-flop synchroniser for one asynchronous input port plus change detect.
//   clock, reset  : clock and synchronous active-high reset
//   din_async_i   : asynchronous port input
//   din_o         : synchronised value (s2)
//   changed_c_o   : one-cycle pulse when s2 differs from its previous value (s3)
module io_port_sync #(
   parameter int unsigned NBITS = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [NBITS-1:0] din_async_i,
   output logic [NBITS-1:0] din_o,
   output logic             changed_c_o
);

   logic [NBITS-1:0] s1_q, s2_q, s3_q;
   // Fills with ones after reset; change detect is held off until s1..s3 all carry
   // post-reset samples, so the reset-to-input transition never looks like an edge.
   logic [2:0]       arm_q;

   // Synchroniser chain and post-reset arming
   always_ff @(posedge clock) begin
      if (reset) begin
         s1_q  <= '0;
         s2_q  <= '0;
         s3_q  <= '0;
         arm_q <= '0;
      end else begin
         s1_q  <= din_async_i;
         s2_q  <= s1_q;
         s3_q  <= s2_q;
         arm_q <= {arm_q[1:0], 1'b1};
      end
   end

   assign din_o       = s2_q;
   assign changed_c_o = arm_q[2] && (s2_q != s3_q);

endmodule

// File: rtl/io_bus_ctrl.sv
// io_bus_ctrl: memory-mapped I/O block between the processor data port and memo.
//   clock, reset : clock and synchronous active-high reset
//   bus (slave)  : mem_address/mem_write_data/mem_write from the processor,
//                  mem_read_data back to it (1-cycle latency), ram_q/ram_wren to memo,
//                  entrada (async inputs), saida (registered outputs), interrupt (level)
// Map from IO_BASE: OUT[k], IN[k], IRQ_MASK, IRQ_PEND (write-1-to-clear).
module io_bus_ctrl
   import io_bus_pkg::*;
#(
   parameter int unsigned NBITS   = 8,
   parameter int unsigned NPORTS  = 4,
   parameter int unsigned ABITS   = NBITS - 2,
   parameter int unsigned IO_BASE = 2**ABITS - (2*NPORTS + 2)
) (
   input  logic          clock,
   input  logic          reset,
   io_bus_ctrl_if.slave  bus
);

   localparam logic [ABITS-1:0] BASE_A  = ABITS'(IO_BASE);
   localparam logic [ABITS-1:0] SPAN_A  = ABITS'(IO_SPAN(NPORTS));
   localparam logic [ABITS-1:0] IN_A    = ABITS'(OFF_IN(NPORTS));
   localparam logic [ABITS-1:0] MASK_A  = ABITS'(OFF_MASK(NPORTS));
   localparam logic [ABITS-1:0] PEND_A  = ABITS'(OFF_PEND(NPORTS));

   logic [ABITS-1:0]             off_c;
   logic                         io_c;
   logic                         wr_io_c;
   io_reg_e                      reg_sel_c;
   logic [NPORTS-1:0]            port_hit_c;
   logic [NBITS-1:0]             rd_val_c;
   logic [NPORTS-1:0][NBITS-1:0] din_c;
   logic [NPORTS-1:0]            set_c;
   logic [NPORTS-1:0]            clr_c;

   logic [NPORTS-1:0][NBITS-1:0] saida_q, saida_d;
   logic [NPORTS-1:0]            mask_q, mask_d;
   logic [NPORTS-1:0]            pend_q, pend_d;
   logic [NBITS-1:0]             io_q;
   logic                         sel_q;
   logic                         irq_q;

   // Per-port input synchronisers
   for (genvar k = 0; k < NPORTS; k++) begin : g_port
      io_port_sync #(.NBITS(NBITS)) u_sync (
         .clock       (clock),
         .reset       (reset),
         .din_async_i (bus.entrada[k*NBITS +: NBITS]),
         .din_o       (din_c[k]),
         .changed_c_o (set_c[k])
      );
   end

   // Address decode; offset wraps in ABITS arithmetic and is only used when io_c
   assign off_c   = bus.mem_address - BASE_A;
   assign io_c    = (bus.mem_address >= BASE_A) && (off_c < SPAN_A);
   assign wr_io_c = bus.mem_write & io_c;

   always_comb begin
      reg_sel_c  = REG_NONE;
      port_hit_c = '0;
      if (io_c) begin
         if (off_c < IN_A)         reg_sel_c = REG_OUT;
         else if (off_c < MASK_A)  reg_sel_c = REG_IN;
         else if (off_c == MASK_A) reg_sel_c = REG_MASK;
         else if (off_c == PEND_A) reg_sel_c = REG_PEND;
      end
      for (int unsigned k = 0; k < NPORTS; k++) begin
         if ((off_c == ABITS'(OFF_OUT(NPORTS) + k)) || (off_c == ABITS'(OFF_IN(NPORTS) + k)))
            port_hit_c[k] = 1'b1;
      end
   end

   // Read mux of current register state (before any same-cycle write)
   always_comb begin
      rd_val_c = '0;
      case (reg_sel_c)
         REG_OUT: begin
            for (int unsigned k = 0; k < NPORTS; k++)
               if (port_hit_c[k]) rd_val_c = saida_q[k];
         end
         REG_IN: begin
            for (int unsigned k = 0; k < NPORTS; k++)
               if (port_hit_c[k]) rd_val_c = din_c[k];
         end
         REG_MASK: rd_val_c = NBITS'(mask_q);
         REG_PEND: rd_val_c = NBITS'(pend_q);
         default:  rd_val_c = '0;
      endcase
   end

   // Register-file next state; IN writes fall through unused
   always_comb begin
      saida_d = saida_q;
      mask_d  = mask_q;
      clr_c   = '0;
      if (wr_io_c) begin
         case (reg_sel_c)
            REG_OUT: begin
               for (int unsigned k = 0; k < NPORTS; k++)
                  if (port_hit_c[k]) saida_d[k] = bus.mem_write_data;
            end
            REG_MASK: mask_d = bus.mem_write_data[NPORTS-1:0];
            REG_PEND: clr_c  = bus.mem_write_data[NPORTS-1:0];
            default:  ;
         endcase
      end
      // A new input change beats a same-cycle clear
      pend_d = (pend_q & ~clr_c) | set_c;
   end

   // State registers
   always_ff @(posedge clock) begin
      if (reset) begin
         saida_q <= '0;
         mask_q  <= '0;
         pend_q  <= '0;
         io_q    <= '0;
         sel_q   <= 1'b0;
         irq_q   <= 1'b0;
      end else begin
         saida_q <= saida_d;
         mask_q  <= mask_d;
         pend_q  <= pend_d;
         io_q    <= rd_val_c;
         sel_q   <= io_c;
         irq_q   <= |(pend_q & mask_q);
      end
   end

   assign bus.saida         = saida_q;
   assign bus.interrupt     = irq_q;
   assign bus.ram_wren      = bus.mem_write & ~io_c;
   assign bus.mem_read_data = sel_q ? io_q : bus.ram_q;

endmodule

// File: tb/tb_io_bus_ctrl.sv
// tb_io_bus_ctrl: self-checking bench for io_bus_ctrl with a behavioural memo model.
module tb_io_bus_ctrl;

   localparam int unsigned NBITS  = 8;
   localparam int unsigned NPORTS = 4;
   localparam int unsigned ABITS  = 6;

   localparam logic [5:0] A_OUT0 = 6'h36;
   localparam logic [5:0] A_OUT1 = 6'h37;
   localparam logic [5:0] A_OUT2 = 6'h38;
   localparam logic [5:0] A_OUT3 = 6'h39;
   localparam logic [5:0] A_IN0  = 6'h3A;
   localparam logic [5:0] A_IN1  = 6'h3B;
   localparam logic [5:0] A_IN2  = 6'h3C;
   localparam logic [5:0] A_MASK = 6'h3E;
   localparam logic [5:0] A_PEND = 6'h3F;

   typedef struct {
      logic       w;
      logic [5:0] a;
      logic [7:0] d;
   } op_t;

   logic clock = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;
   logic [7:0] exp_q[$];
   logic [7:0] mem_m [64];

   always #5 clock = ~clock;

   io_bus_ctrl_if #(.NBITS(NBITS), .NPORTS(NPORTS), .ABITS(ABITS)) bus ();

   io_bus_ctrl #(.NBITS(NBITS), .NPORTS(NPORTS), .ABITS(ABITS)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // memo model: synchronous read, write when ram_wren
   always @(posedge clock) begin
      if (bus.ram_wren === 1'b1) mem_m[bus.mem_address] <= bus.mem_write_data;
      bus.ram_q <= mem_m[bus.mem_address];
   end

   task automatic drive(input logic w, input logic [5:0] a, input logic [7:0] d);
      @(negedge clock);
      bus.mem_write      = w;
      bus.mem_address    = a;
      bus.mem_write_data = d;
   endtask

   task automatic after_edge();
      @(posedge clock);
      #2;
   endtask

   task automatic test_reset();
      logic [7:0] got, exp;
      @(negedge clock);
      reset = 1'b1;
      bus.entrada = '1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      #1;
      checks++;
      if (bus.saida !== 32'h0) begin
         failures++; $display("FAIL reset_saida got=%h exp=0", bus.saida);
      end
      checks++;
      if (bus.interrupt !== 1'b0) begin
         failures++; $display("FAIL reset_irq got=%b exp=0", bus.interrupt);
      end
      checks++;
      if (bus.mem_read_data !== 8'h00) begin
         failures++; $display("FAIL reset_rdata got=%h exp=00 (ram_q)", bus.mem_read_data);
      end
      // Unmask everything so any spurious pend would also raise interrupt
      bus.mem_write = 1'b1; bus.mem_address = A_MASK; bus.mem_write_data = 8'h0F;
      after_edge();
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 6'h00, 8'h00);
         after_edge();
         checks++;
         if (bus.interrupt !== 1'b0) begin
            failures++; $display("FAIL reset_idle_irq cycle=%0d got=%b exp=0", i, bus.interrupt);
         end
      end
      drive(1'b0, A_PEND, 8'h00); exp_q.push_back(8'h00);
      after_edge();
      got = bus.mem_read_data; exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin
         failures++; $display("FAIL reset_pend got=%h exp=%h", got, exp);
      end
      // Park inputs at zero with a clean pend register for the following tests
      drive(1'b1, A_MASK, 8'h00);
      bus.entrada = '0;
      repeat (5) drive(1'b0, 6'h00, 8'h00);
      drive(1'b1, A_PEND, 8'h0F);
      drive(1'b0, A_PEND, 8'h00); exp_q.push_back(8'h00);
      after_edge();
      got = bus.mem_read_data; exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin
         failures++; $display("FAIL reset_cleanup_pend got=%h exp=%h", got, exp);
      end
   endtask

   task automatic test_out_write();
      logic [7:0] got, exp;
      drive(1'b1, A_OUT1, 8'hA5); exp_q.push_back(8'h00);
      #1;
      checks++;
      if (bus.ram_wren !== 1'b0) begin
         failures++; $display("FAIL out_wren got=%b exp=0", bus.ram_wren);
      end
      after_edge();
      checks++;
      if (bus.saida[15:8] !== 8'hA5) begin
         failures++; $display("FAIL out_saida got=%h exp=a5", bus.saida[15:8]);
      end
      got = bus.mem_read_data; exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin
         failures++; $display("FAIL out_old_value got=%h exp=%h", got, exp);
      end
      drive(1'b0, A_OUT1, 8'h00); exp_q.push_back(8'hA5);
      after_edge();
      got = bus.mem_read_data; exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin
         failures++; $display("FAIL out_readback got=%h exp=%h", got, exp);
      end
   endtask

   task automatic test_pass_through();
      logic [7:0] got, exp;
      drive(1'b1, 6'd5, 8'h3C); exp_q.push_back(8'h00);
      #1;
      checks++;
      if (bus.ram_wren !== 1'b1) begin
         failures++; $display("FAIL pt_wren got=%b exp=1", bus.ram_wren);
      end
      after_edge();
      got = bus.mem_read_data; exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin
         failures++; $display("FAIL pt_old got=%h exp=%h", got, exp);
      end
      drive(1'b0, 6'd5, 8'h00); exp_q.push_back(8'h3C);
      #1;
      checks++;
      if (bus.ram_wren !== 1'b0) begin
         failures++; $display("FAIL pt_load_wren got=%b exp=0", bus.ram_wren);
      end
      after_edge();
      got = bus.mem_read_data; exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin
         failures++; $display("FAIL pt_readback got=%h exp=%h", got, exp);
      end
   endtask

   task automatic test_interrupt();
      logic [7:0] got, exp;
      drive(1'b1, A_MASK, 8'h04);
      drive(1'b0, 6'h00, 8'h00);
      bus.entrada[23:16] = 8'h11;
      for (int e = 1; e <= 4; e++) begin
         after_edge();
         if (e >= 3) begin
            checks++;
            if (bus.interrupt !== (e == 4)) begin
               failures++; $display("FAIL irq_rise edge=%0d got=%b exp=%b", e, bus.interrupt, e == 4);
            end
         end
      end
      drive(1'b0, A_IN2, 8'h00); exp_q.push_back(8'h11);
      after_edge();
      got = bus.mem_read_data; exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin
         failures++; $display("FAIL irq_in2 got=%h exp=%h", got, exp);
      end
      drive(1'b0, A_PEND, 8'h00); exp_q.push_back(8'h04);
      after_edge();
      got = bus.mem_read_data; exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin
         failures++; $display("FAIL irq_pend got=%h exp=%h", got, exp);
      end
      drive(1'b1, A_PEND, 8'h04);
      after_edge();
      checks++;
      if (bus.interrupt !== 1'b1) begin
         failures++; $display("FAIL irq_clr_t1 got=%b exp=1", bus.interrupt);
      end
      drive(1'b0, 6'h00, 8'h00);
      after_edge();
      checks++;
      if (bus.interrupt !== 1'b0) begin
         failures++; $display("FAIL irq_clr_t2 got=%b exp=0", bus.interrupt);
      end
      drive(1'b0, A_PEND, 8'h00); exp_q.push_back(8'h00);
      after_edge();
      got = bus.mem_read_data; exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin
         failures++; $display("FAIL irq_pend_cleared got=%h exp=%h", got, exp);
      end
   endtask

   task automatic test_masked_simul();
      logic [7:0] got, exp;
      drive(1'b1, A_MASK, 8'h00);
      drive(1'b0, 6'h00, 8'h00);
      bus.entrada[7:0] = 8'h01;
      for (int e = 1; e <= 5; e++) begin
         after_edge();
         checks++;
         if (bus.interrupt !== 1'b0) begin
            failures++; $display("FAIL masked_irq edge=%0d got=%b exp=0", e, bus.interrupt);
         end
         if (e < 5) drive(1'b0, 6'h00, 8'h00);
      end
      drive(1'b0, A_PEND, 8'h00); exp_q.push_back(8'h01);
      after_edge();
      got = bus.mem_read_data; exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin
         failures++; $display("FAIL masked_pend got=%h exp=%h", got, exp);
      end
      // Clear lands in the same cycle the new change is detected
      drive(1'b0, 6'h00, 8'h00);
      bus.entrada[7:0] = 8'h02;
      after_edge();
      drive(1'b0, 6'h00, 8'h00);
      after_edge();
      drive(1'b1, A_PEND, 8'h01);
      after_edge();
      drive(1'b0, A_PEND, 8'h00); exp_q.push_back(8'h01);
      after_edge();
      got = bus.mem_read_data; exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin
         failures++; $display("FAIL simul_set_wins got=%h exp=%h", got, exp);
      end
      drive(1'b1, A_PEND, 8'h01);
      drive(1'b0, A_PEND, 8'h00); exp_q.push_back(8'h00);
      after_edge();
      got = bus.mem_read_data; exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin
         failures++; $display("FAIL simul_cleared got=%h exp=%h", got, exp);
      end
   endtask

   task automatic test_write_in();
      logic [7:0] got, exp;
      drive(1'b1, A_IN0, 8'hFF);
      #1;
      checks++;
      if (bus.ram_wren !== 1'b0) begin
         failures++; $display("FAIL win_wren got=%b exp=0", bus.ram_wren);
      end
      drive(1'b0, A_IN0, 8'h00); exp_q.push_back(8'h02);
      after_edge();
      got = bus.mem_read_data; exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin
         failures++; $display("FAIL win_in0 got=%h exp=%h", got, exp);
      end
   endtask

   task automatic test_back_to_back();
      op_t        ops[$];
      logic [7:0] exps[$];
      logic [7:0] got, exp;
      ops.push_back('{1'b1, A_OUT0, 8'h11}); exps.push_back(8'h00);
      ops.push_back('{1'b1, A_OUT2, 8'h22}); exps.push_back(8'h00);
      ops.push_back('{1'b1, A_OUT3, 8'h33}); exps.push_back(8'h00);
      ops.push_back('{1'b1, A_MASK, 8'hF5}); exps.push_back(8'h00);
      ops.push_back('{1'b1, 6'd16,  8'h77}); exps.push_back(8'h00);
      ops.push_back('{1'b0, A_OUT0, 8'h00}); exps.push_back(8'h11);
      ops.push_back('{1'b0, A_OUT1, 8'h00}); exps.push_back(8'hA5);
      ops.push_back('{1'b0, A_OUT2, 8'h00}); exps.push_back(8'h22);
      ops.push_back('{1'b0, A_OUT3, 8'h00}); exps.push_back(8'h33);
      ops.push_back('{1'b0, A_MASK, 8'h00}); exps.push_back(8'h05);
      ops.push_back('{1'b0, 6'd16,  8'h00}); exps.push_back(8'h77);
      ops.push_back('{1'b0, A_IN2,  8'h00}); exps.push_back(8'h11);
      ops.push_back('{1'b0, A_IN1,  8'h00}); exps.push_back(8'h00);
      ops.push_back('{1'b0, 6'd5,   8'h00}); exps.push_back(8'h3C);
      ops.push_back('{1'b0, A_PEND, 8'h00}); exps.push_back(8'h00);
      foreach (ops[i]) begin
         drive(ops[i].w, ops[i].a, ops[i].d);
         if (!ops[i].w) exp_q.push_back(exps[i]);
         after_edge();
         if (!ops[i].w) begin
            got = bus.mem_read_data; exp = exp_q.pop_front(); checks++;
            if (got !== exp) begin
               failures++; $display("FAIL b2b_load addr=%h got=%h exp=%h", ops[i].a, got, exp);
            end
         end
      end
      checks++;
      if (bus.saida !== 32'h3322A511) begin
         failures++; $display("FAIL b2b_saida got=%h exp=3322a511", bus.saida);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] got, exp;
      drive(1'b1, A_MASK, 8'h04);
      drive(1'b0, 6'h00, 8'h00);
      bus.entrada[23:16] = 8'h33;
      repeat (4) after_edge();
      checks++;
      if (bus.interrupt !== 1'b1) begin
         failures++; $display("FAIL mid_irq_before got=%b exp=1", bus.interrupt);
      end
      @(negedge clock);
      reset = 1'b1;
      after_edge();
      checks++;
      if ((bus.saida !== 32'h0) || (bus.interrupt !== 1'b0)) begin
         failures++; $display("FAIL mid_reset_outs saida=%h irq=%b exp=0/0", bus.saida, bus.interrupt);
      end
      checks++;
      if (bus.mem_read_data !== 8'h00) begin
         failures++; $display("FAIL mid_reset_rdata got=%h exp=00", bus.mem_read_data);
      end
      @(negedge clock);
      reset = 1'b0;
      repeat (5) drive(1'b0, 6'h00, 8'h00);
      drive(1'b0, A_PEND, 8'h00); exp_q.push_back(8'h00);
      after_edge();
      got = bus.mem_read_data; exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin
         failures++; $display("FAIL mid_pend got=%h exp=%h", got, exp);
      end
      drive(1'b0, A_MASK, 8'h00); exp_q.push_back(8'h00);
      after_edge();
      got = bus.mem_read_data; exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin
         failures++; $display("FAIL mid_mask got=%h exp=%h", got, exp);
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem_m[i] = 8'h00;
      reset              = 1'b1;
      bus.mem_write      = 1'b0;
      bus.mem_address    = '0;
      bus.mem_write_data = '0;
      bus.entrada        = '1;
      test_reset();
      test_out_write();
      test_pass_through();
      test_interrupt();
      test_masked_simul();
      test_write_in();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
